jtag_dr_bank: RTL
=================

Name: jtag_dr_bank

Overview:
- Parametrised JTAG data-register bank: one DR shift path plus IDCODE, BYPASS, BSR-sample and N_USER independent user registers.
- Selected by the current instruction; performs Capture-DR / Shift-DR / Update-DR itself.
- Sits between the TAP controller (state strobes, IR) and external logic consuming user data.
- Adds per-register write lock and update-strobe outputs.

Parameters:
- DR_W, 32, width of IDCODE, BSR, user registers and shift path (≥2).
- N_USER, 4, number of user registers (1..8).
- IR_W, 4, instruction width (≥4).
- ID_CODE, 32'h4BA0_0477, IDCODE value; bit 0 must be 1.
- USER_RST, '0, reset value of every user register (DR_W bits).

Ports:
- i_tclk  in  1  TCK.
- i_trst_n  in  1  TRST, async active-low.
- i_tdi  in  1  serial data in.
- i_stateIsTlr  in  1  TAP in Test-Logic-Reset.
- i_stateIsCaptureDr  in  1  TAP in Capture-DR.
- i_stateIsShiftDr  in  1  TAP in Shift-DR.
- i_stateIsUpdateDr  in  1  TAP in Update-DR.
- i_instrReg  in  IR_W  current instruction.
- i_bsr  in  DR_W  boundary-scan sample input.
- i_userLock  in  N_USER  per-user write lock.
- o_tdo  out  1  serial data out (TAP retimes on falling edge).
- o_userData  out  N_USER*DR_W  user register k at bits [k*DR_W +: DR_W].
- o_userUpdated  out  N_USER  one-cycle strobe when user k is written.

Behaviour:
- Reset is decided: reset i_trst_n, asynchronous, active-low; clock i_tclk.
- Instruction decode:
  - IDCODE = 1.
  - SAMPLE = 2.
  - USER_k = 8+k, for k < N_USER.
  - BYPASS = all ones.
  - Any other code is treated as BYPASS.
- State: sr_q[DR_W-1:0], bypass_q, user_q[k], upd_q[k].
- Async reset (i_trst_n=0): sr_q=0, bypass_q=0, user_q[k]=USER_RST, upd_q=0, so o_userUpdated=0 and o_tdo=0.
- Strobe priority (per rising edge, highest first): TLR > CaptureDr > ShiftDr > UpdateDr.
- TLR: user_q[k]=USER_RST, sr_q=0, bypass_q=0, no strobe.
- Capture (1 cycle):
  - IDCODE: sr_q=ID_CODE.
  - SAMPLE: sr_q=i_bsr, sampled this edge.
  - USER_k: sr_q=user_q[k].
  - BYPASS: bypass_q=0; sr_q unchanged.
- Shift:
  - BYPASS: bypass_q<=i_tdi.
  - Else: sr_q<={i_tdi, sr_q[DR_W-1:1]}, LSB first.
  - Each shift edge moves exactly one bit; DR_W shifts fully replace sr_q.
- o_tdo (combinational):
  - BYPASS: bypass_q.
  - Else: sr_q[0].
- Update:
  - USER_k with i_userLock[k]=0: user_q[k]<=sr_q and upd_q[k]=1 for exactly the next cycle.
  - USER_k with i_userLock[k]=1: no write, no strobe.
  - IDCODE/SAMPLE/BYPASS: read-only, no effect.
- upd_q clears the cycle after it is set. Back-to-back Update cycles pulse on each.
- Instruction change mid-Shift: the tdo source switches immediately; sr_q keeps its contents.
- No strobe: all state holds.
- Only one TAP strobe is normally active; the priority order above is the defined behaviour if several are set.
- i_trst_n asserting mid-shift: immediate reset; partial data is lost and no strobe is generated.

Test Plan:
- Async reset, then IDCODE, Capture + 32 Shift with tdi=0 -> o_tdo sequence LSB-first equals 32'h4BA0_0477 (first bit 1).
- BYPASS (IR=4'hF), Capture then Shift of tdi pattern 1,0,1,1 -> o_tdo = 0,1,0,1 (one-cycle delay, captured 0 first); IR=4'h5 gives identical behaviour.
- USER_2 (IR=4'hA), Capture + 32 Shift of 32'hDEAD_BEEF, Update -> o_userData[95:64]=32'hDEAD_BEEF, o_userUpdated=4'b0100 for exactly 1 cycle; other users unchanged.
- Same with i_userLock[2]=1 -> user 2 keeps its prior value, o_userUpdated stays 0; re-Capture USER_2 shifts out the old value.
- SAMPLE with i_bsr=32'h0000_00A5, Capture + 8 Shift -> o_tdo = 1,0,1,0,0,1,0,1; Update leaves all users unchanged.
- Write user 0 = 32'h1, then TLR strobe -> all users = USER_RST; separately, i_trst_n low mid-shift -> sr_q=0 and o_tdo=0 at once, no strobe.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// ============================================================================
// Module   : jtag_dr_bank
// Brief    : JTAG data-register bank (IDCODE, BYPASS, SAMPLE, user regs)
//            with a shared DR shift path, per-user write lock and update strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_dr_bank #(
    parameter int              DR_W     = 32,
    parameter int              N_USER   = 4,
    parameter int              IR_W     = 4,
    parameter logic [DR_W-1:0] ID_CODE  = 32'h4BA0_0477,
    parameter logic [DR_W-1:0] USER_RST = '0
) (
    input  logic                     i_tclk,
    input  logic                     i_trst_n,
    input  logic                     i_tdi,
    input  logic                     i_stateIsTlr,
    input  logic                     i_stateIsCaptureDr,
    input  logic                     i_stateIsShiftDr,
    input  logic                     i_stateIsUpdateDr,
    input  logic [IR_W-1:0]          i_instrReg,
    input  logic [DR_W-1:0]          i_bsr,
    input  logic [N_USER-1:0]        i_userLock,
    output logic                     o_tdo,
    output logic [N_USER*DR_W-1:0]   o_userData,
    output logic [N_USER-1:0]        o_userUpdated
);

    localparam logic [IR_W-1:0] c_IR_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] c_IR_SAMPLE = IR_W'(2);

    logic [DR_W-1:0]   r_sr;
    logic              r_bypass;
    logic [DR_W-1:0]   r_user [N_USER];
    logic [N_USER-1:0] r_upd;

    logic              w_isId;
    logic              w_isSample;
    logic [N_USER-1:0] w_userHit;
    logic              w_isUser;
    logic              w_isBypass;
    logic [DR_W-1:0]   w_userSel;
    logic              w_doUpdate;

    assign w_isId     = (i_instrReg == c_IR_IDCODE);
    assign w_isSample = (i_instrReg == c_IR_SAMPLE);
    assign w_isUser   = |w_userHit;
    // Every unrecognised code behaves as BYPASS, including all-ones.
    assign w_isBypass = ~(w_isId | w_isSample | w_isUser);

    // Update only takes effect when no higher-priority strobe is present.
    assign w_doUpdate = i_stateIsUpdateDr & ~i_stateIsTlr
                      & ~i_stateIsCaptureDr & ~i_stateIsShiftDr;

    always_comb begin
        w_userSel = '0;
        for (int k = 0; k < N_USER; k++) begin
            if (w_userHit[k]) begin
                w_userSel = r_user[k];
            end
        end
    end

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_sr     <= '0;
            r_bypass <= 1'b0;
        end else if (i_stateIsTlr) begin
            r_sr     <= '0;
            r_bypass <= 1'b0;
        end else if (i_stateIsCaptureDr) begin
            if (w_isId) begin
                r_sr <= ID_CODE;
            end else if (w_isSample) begin
                r_sr <= i_bsr;
            end else if (w_isUser) begin
                r_sr <= w_userSel;
            end else begin
                r_bypass <= 1'b0;
            end
        end else if (i_stateIsShiftDr) begin
            if (w_isBypass) begin
                r_bypass <= i_tdi;
            end else begin
                r_sr <= {i_tdi, r_sr[DR_W-1:1]};
            end
        end
    end

    generate
        for (genvar k = 0; k < N_USER; k++) begin : g_user
            assign w_userHit[k] = (i_instrReg == IR_W'(8 + k));

            always_ff @(posedge i_tclk or negedge i_trst_n) begin
                if (!i_trst_n) begin
                    r_user[k] <= USER_RST;
                    r_upd[k]  <= 1'b0;
                end else if (i_stateIsTlr) begin
                    r_user[k] <= USER_RST;
                    r_upd[k]  <= 1'b0;
                end else if (w_doUpdate && w_userHit[k] && !i_userLock[k]) begin
                    r_user[k] <= r_sr;
                    r_upd[k]  <= 1'b1;
                end else begin
                    r_upd[k]  <= 1'b0;
                end
            end

            assign o_userData[k*DR_W +: DR_W] = r_user[k];
        end
    endgenerate

    assign o_tdo         = w_isBypass ? r_bypass : r_sr[0];
    assign o_userUpdated = r_upd;

endmodule

`default_nettype wire
